// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types for the register writeback controller: queue depth default,
// queued entry layout and the arbitration source encoding.
package regwb_pkg;

  localparam int unsigned WB_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_LD  = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/reg_writeback_ctrl_fifo.sv
// Circular writeback queue. Exposes per-slot valid bits, slot contents and
// the read pointer so the parent can scan entries in age order.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [PW-1:0]           rd_ptr,
  output logic [DEPTH-1:0]        entry_valid,
  output wb_entry_t [DEPTH-1:0]   entries
);

  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // Pointer, occupancy and slot updates; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
      entries     <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr]     <= push_entry;
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback controller: arbitrates ALU/load results into an in-order queue,
// drains it to the register-file write port, and forwards pending data.
module reg_writeback_ctrl
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        wb_stall,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  output logic        regwrite_ctrl,
  input  logic [4:0]  byp_addr_1,
  input  logic [4:0]  byp_addr_2,
  output logic        byp_hit_1,
  output logic [31:0] byp_data_1,
  output logic        byp_hit_2,
  output logic [31:0] byp_data_2,
  output logic [31:0] busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_src_t                prio, prio_next;
  logic                   full, empty, ld_go, alu_go, push, pop;
  wb_entry_t              acc_entry, head;
  logic [PW-1:0]          rd_ptr, idx;
  logic [DEPTH-1:0]       ent_valid;
  wb_entry_t [DEPTH-1:0]  ents;

  assign ld_ready  = !full && (!alu_valid || prio == SRC_LD);
  assign alu_ready = !full && (!ld_valid  || prio == SRC_ALU);
  assign ld_go     = ld_valid  && ld_ready;
  assign alu_go    = alu_valid && alu_ready;
  assign pop       = !empty && !wb_stall;
  assign head      = ents[rd_ptr];

  // Round-robin state: the loser of a granted contested cycle wins next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio <= SRC_LD;
    else        prio <= prio_next;
  end

  // Next arbitration state and the selected request; rd=0 is accepted but dropped.
  always_comb begin
    prio_next = prio;
    if (ld_valid && alu_valid && !full)
      prio_next = (prio == SRC_LD) ? SRC_ALU : SRC_LD;
    acc_entry.rd   = ld_go ? ld_rd   : alu_rd;
    acc_entry.data = ld_go ? ld_data : alu_data;
    push = (ld_go || alu_go) && (acc_entry.rd != '0);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (acc_entry),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .rd_ptr      (rd_ptr),
    .entry_valid (ent_valid),
    .entries     (ents)
  );

  // Register-file write port follows the head entry, zero when idle.
  always_comb begin
    regwrite_ctrl  = pop;
    write_register = pop ? head.rd   : '0;
    write_data     = pop ? head.data : '0;
  end

  // Scan oldest to youngest so the last match seen is the youngest write.
  always_comb begin
    busy_o     = '0;
    byp_hit_1  = 1'b0;
    byp_data_1 = '0;
    byp_hit_2  = 1'b0;
    byp_data_2 = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (ent_valid[idx]) begin
        busy_o[ents[idx].rd] = 1'b1;
        if (byp_addr_1 != '0 && ents[idx].rd == byp_addr_1) begin
          byp_hit_1  = 1'b1;
          byp_data_1 = ents[idx].data;
        end
        if (byp_addr_2 != '0 && ents[idx].rd == byp_addr_2) begin
          byp_hit_2  = 1'b1;
          byp_data_2 = ents[idx].data;
        end
      end
    end
    busy_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: accepted requests are queued in
// the bench model and compared against the write port as they drain.
module tb_reg_writeback_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, wb_stall = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0, byp_addr_1 = '0, byp_addr_2 = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready, regwrite_ctrl, byp_hit_1, byp_hit_2;
  logic [4:0]  write_register;
  logic [31:0] write_data, byp_data_1, byp_data_2, busy_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  bit          prio_ld = 1'b1;
  int unsigned n_checks = 0, n_pass = 0;

  reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_valid       (ld_valid),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .wb_stall       (wb_stall),
    .write_register (write_register),
    .write_data     (write_data),
    .regwrite_ctrl  (regwrite_ctrl),
    .byp_addr_1     (byp_addr_1),
    .byp_addr_2     (byp_addr_2),
    .byp_hit_1      (byp_hit_1),
    .byp_data_1     (byp_data_1),
    .byp_hit_2      (byp_hit_2),
    .byp_data_2     (byp_data_2),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    foreach (sb[i]) b[sb[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic logic [32:0] exp_byp(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != '0)
      foreach (sb[i]) if (sb[i].rd == a) r = {1'b1, sb[i].data};
    return r;
  endfunction

  task automatic drive(input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input bit av, input logic [4:0] ard, input logic [31:0] adat);
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
  endtask

  // One clock: compare outputs at negedge, then advance the model at posedge.
  task automatic step(output bit la, output bit aa);
    bit full, ldr, alur, wr;
    logic [32:0] b1, b2;
    @(negedge clk);
    full = (sb.size() == DEPTH);
    ldr  = !full && (!alu_valid || prio_ld);
    alur = !full && (!ld_valid || !prio_ld);
    wr   = (sb.size() != 0) && !wb_stall;
    b1   = exp_byp(byp_addr_1);
    b2   = exp_byp(byp_addr_2);
    check("ld_ready", 32'(ld_ready), 32'(ldr));
    check("alu_ready", 32'(alu_ready), 32'(alur));
    check("regwrite", 32'(regwrite_ctrl), 32'(wr));
    check("wr_reg", 32'(write_register), wr ? 32'(sb[0].rd) : 32'd0);
    check("wr_data", write_data, wr ? sb[0].data : 32'd0);
    check("busy", busy_o, exp_busy());
    check("byp_hit_1", 32'(byp_hit_1), 32'(b1[32]));
    check("byp_data_1", byp_data_1, b1[31:0]);
    check("byp_hit_2", 32'(byp_hit_2), 32'(b2[32]));
    check("byp_data_2", byp_data_2, b2[31:0]);
    la = ld_valid && ldr;
    aa = alu_valid && alur;
    @(posedge clk);
    if (wr) void'(sb.pop_front());
    if (la && ld_rd != '0)       sb.push_back('{rd: ld_rd, data: ld_data});
    else if (aa && alu_rd != '0) sb.push_back('{rd: alu_rd, data: alu_data});
    if (ld_valid && alu_valid && !full) prio_ld = !prio_ld;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bit la, aa;
    drive(0, '0, '0, 0, '0, '0);
    for (int unsigned i = 0; i < n; i++) step(la, aa);
  endtask

  initial begin
    bit la, aa;
    int unsigned li, ai, k;

    // Outputs while reset is held
    #12;
    check("rst_regwrite", 32'(regwrite_ctrl), 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_wr_data", write_data, 32'd0);
    check("rst_hit_1", 32'(byp_hit_1), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Single ALU write into an empty queue
    byp_addr_1 = 5'd5;
    drive(0, '0, '0, 1, 5'd5, 32'h1234);
    step(la, aa);
    idle(3);

    // Contested traffic alternates ld, alu, ld, alu
    li = 0; ai = 0;
    byp_addr_1 = 5'd2; byp_addr_2 = 5'd10;
    for (int unsigned c = 0; c < 8; c++) begin
      drive(li < 4, 5'(li + 1), 32'h100 + li, ai < 4, 5'(ai + 9), 32'h900 + ai);
      step(la, aa);
      if (la) li++;
      if (aa) ai++;
    end
    check("contest_ld_done", li, 32'd4);
    check("contest_alu_done", ai, 32'd4);
    idle(3);

    // Stalled write port: queue fills and the fifth offer is refused
    wb_stall = 1'b1; k = 0;
    byp_addr_1 = 5'd21; byp_addr_2 = 5'd23;
    for (int unsigned c = 0; c < 5; c++) begin
      drive(0, '0, '0, 1, 5'(20 + k), 32'hA000 + k);
      step(la, aa);
      if (aa) k++;
    end
    check("stall_accepted", k, 32'd4);
    wb_stall = 1'b0;
    idle(5);

    // Two pending writes to the same register: youngest data forwards
    wb_stall = 1'b1;
    byp_addr_1 = 5'd7; byp_addr_2 = 5'd0;
    drive(1, 5'd7, 32'hA, 0, '0, '0);
    step(la, aa);
    drive(1, 5'd7, 32'hB, 0, '0, '0);
    step(la, aa);
    idle(1);
    wb_stall = 1'b0;
    idle(3);

    // Writes to x0 are accepted and dropped
    byp_addr_1 = 5'd0;
    drive(0, '0, '0, 1, 5'd0, 32'hFFFF);
    step(la, aa);
    check("rd0_accepted", 32'(aa), 32'd1);
    idle(2);

    // Random traffic exercises pointer wrap and full conditions
    for (int unsigned c = 0; c < 80; c++) begin
      wb_stall   = ($urandom_range(0, 3) == 0);
      byp_addr_1 = 5'($urandom_range(0, 7));
      byp_addr_2 = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
      step(la, aa);
    end
    wb_stall = 1'b0;
    idle(6);

    // Asynchronous reset with three entries pending
    wb_stall = 1'b1;
    byp_addr_1 = 5'd13; byp_addr_2 = 5'd15;
    for (int unsigned c = 0; c < 3; c++) begin
      drive(0, '0, '0, 1, 5'(13 + c), 32'hC0 + c);
      step(la, aa);
    end
    drive(0, '0, '0, 0, '0, '0);
    wb_stall = 1'b0;
    #2;
    check("pre_rst_regwrite", 32'(regwrite_ctrl), 32'd1);
    check("pre_rst_busy", busy_o, exp_busy());
    rst_n = 1'b0;
    #1;
    check("async_regwrite", 32'(regwrite_ctrl), 32'd0);
    check("async_busy", busy_o, 32'd0);
    check("async_wr_reg", 32'(write_register), 32'd0);
    check("async_hit_1", 32'(byp_hit_1), 32'd0);
    sb.delete();
    prio_ld = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(1);
    drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    step(la, aa);
    check("post_rst_ld_first", 32'(la), 32'd1);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
